// File: rtl/formation_if.sv
// Handshake bundle between game control, renderers and the formation controller.
// The master side drives tick/start/kill and observes the formation state.
interface formation_if #(
    parameter int N = 24
) ();
    logic         frame_tick;
    logic         start;
    logic         kill_valid;
    logic [1:0]   kill_row;
    logic [2:0]   kill_col;
    logic [9:0]   base_x;
    logic [9:0]   base_y;
    logic [N-1:0] alive;
    logic         dir;
    logic         step_pulse;
    logic         wave_clear;
    logic         landed;

    modport master (
        output frame_tick, start, kill_valid, kill_row, kill_col,
        input  base_x, base_y, alive, dir, step_pulse, wave_clear, landed
    );

    modport slave (
        input  frame_tick, start, kill_valid, kill_row, kill_col,
        output base_x, base_y, alive, dir, step_pulse, wave_clear, landed
    );
endinterface

// File: rtl/formation_controller.sv
// Enemy formation sequencer: marches the block, reverses and descends at the
// playfield edges, speeds up as enemies die, flags wave clear and landing.
module formation_controller #(
    parameter int COLS       = 8,
    parameter int ROWS       = 3,
    parameter int X_START    = 40,
    parameter int Y_START    = 40,
    parameter int COL_PITCH  = 64,
    parameter int ROW_PITCH  = 50,
    parameter int ENEMY_W    = 32,
    parameter int ENEMY_H    = 24,
    parameter int STEP_X     = 8,
    parameter int STEP_Y     = 16,
    parameter int X_MIN      = 32,
    parameter int X_MAX      = 608,
    parameter int INVADE_Y   = 440,
    parameter int PERIOD_MIN = 2
) (
    input logic        clk,
    input logic        reset,
    formation_if.slave bus
);
    localparam int NE = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, MARCH, CLEAR, LANDED} state_t;

    state_t          state_q, state_d;
    logic [9:0]      base_x_q, base_x_d;
    logic [9:0]      base_y_q, base_y_d;
    logic            dir_q, dir_d;
    logic            step_q, step_d;
    logic [NE-1:0]   alive_q, alive_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [NE-1:0]   kill_mask;
    logic [COLS-1:0] col_any;
    logic [7:0]      period;
    logic [2:0]      lc, rc;
    logic [1:0]      lr;
    logic [10:0]     r_ext, l_ext, y_desc, low_ext;
    logic            march, reload, tick_hit, edge_hit, land_hit;

    always_comb begin : occupancy
        col_any = '0;
        lc      = '0;
        rc      = '0;
        lr      = '0;
        period  = 8'(PERIOD_MIN);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_q[r*COLS+c]) begin
                    col_any[c] = 1'b1;
                    lr         = 2'(r);
                end
                period = period + 8'(alive_q[r*COLS+c]);
            end
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lc = 3'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) rc = 3'(c);
        end
    end

    always_comb begin : kill_decode
        kill_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (bus.kill_valid && bus.kill_row == 2'(r)
                    && bus.kill_col == 3'(c))
                    kill_mask[r*COLS+c] = 1'b1;
            end
        end
    end

    // A kill can shrink P below a pending count, so the step is due at >=.
    always_comb begin : decide
        march    = (state_q == MARCH);
        reload   = bus.start && !march;
        tick_hit = march && bus.frame_tick && (alive_q != '0)
                   && (cnt_q >= period - 8'd1);
        r_ext    = {1'b0, base_x_q} + 11'(rc) * 11'(COL_PITCH)
                   + 11'(ENEMY_W);
        l_ext    = {1'b0, base_x_q} + 11'(lc) * 11'(COL_PITCH);
        edge_hit = dir_q ? (r_ext + 11'(STEP_X) > 11'(X_MAX))
                         : (l_ext < 11'(X_MIN + STEP_X));
        y_desc   = {1'b0, base_y_q} + 11'(STEP_Y);
        low_ext  = y_desc + 11'(lr) * 11'(ROW_PITCH) + 11'(ENEMY_H);
        land_hit = tick_hit && edge_hit && (low_ext >= 11'(INVADE_Y));
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (bus.start) state_d = MARCH;
            MARCH: begin
                if (land_hit)              state_d = LANDED;
                else if (alive_q == '0)    state_d = CLEAR;
            end
            CLEAR:  if (bus.start) state_d = MARCH;
            LANDED: if (bus.start) state_d = MARCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : fsm_out
        bus.wave_clear = (state_q == CLEAR);
        bus.landed     = (state_q == LANDED);
    end

    always_comb begin : datapath
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        dir_d    = dir_q;
        alive_d  = alive_q;
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        if (reload) begin
            base_x_d = 10'(X_START);
            base_y_d = 10'(Y_START);
            dir_d    = 1'b1;
            alive_d  = '1;
            cnt_d    = '0;
        end else if (march) begin
            if (bus.frame_tick) cnt_d = tick_hit ? 8'd0 : cnt_q + 8'd1;
            if (tick_hit) begin
                step_d = 1'b1;
                if (edge_hit) begin
                    base_y_d = y_desc[9:0];
                    dir_d    = ~dir_q;
                end else if (dir_q) begin
                    base_x_d = base_x_q + 10'(STEP_X);
                end else begin
                    base_x_d = base_x_q - 10'(STEP_X);
                end
            end
            alive_d = alive_q & ~kill_mask;
        end
    end

    always_ff @(posedge clk) begin : data_reg
        if (!reset) begin
            base_x_q <= 10'(X_START);
            base_y_q <= 10'(Y_START);
            dir_q    <= 1'b1;
            alive_q  <= '1;
            cnt_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            dir_q    <= dir_d;
            alive_q  <= alive_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
        end
    end

    assign bus.base_x     = base_x_q;
    assign bus.base_y     = base_y_q;
    assign bus.dir        = dir_q;
    assign bus.alive      = alive_q;
    assign bus.step_pulse = step_q;
endmodule

// File: tb/tb_formation_controller.sv
// Directed bench for formation_controller with a reference model feeding a
// step scoreboard; the landing line is lowered to 200 to reach it quickly.
module tb_formation_controller;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    formation_if #(.N(24)) bus ();

    formation_controller #(.INVADE_Y(200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [9:0] bx;
        logic [9:0] by;
        logic       dir;
        logic       landed;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pushes = 0;
    int          m_bx, m_by, m_cnt, m_state;
    bit          m_dir;
    logic [23:0] m_alive;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reload();
        m_bx    = 40;
        m_by    = 40;
        m_dir   = 1'b1;
        m_alive = '1;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int   lc, rc, lr;
        exp_t e;
        lc = -1;
        rc = 0;
        lr = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_alive[c] | m_alive[8+c] | m_alive[16+c]) begin
                if (lc < 0) lc = c;
                rc = c;
            end
        end
        for (int r = 0; r < 3; r++) if (m_alive[r*8 +: 8] != 0) lr = r;
        if (m_dir ? (m_bx + rc * 64 + 32 + 8 > 608) : (m_bx + lc * 64 < 40)) begin
            m_by  = m_by + 16;
            m_dir = !m_dir;
            if (m_by + lr * 50 + 24 >= 200) m_state = 3;
        end else begin
            m_bx = m_dir ? m_bx + 8 : m_bx - 8;
        end
        e.bx     = 10'(m_bx);
        e.by     = 10'(m_by);
        e.dir    = m_dir;
        e.landed = (m_state == 3);
        sb.push_back(e);
        pushes++;
    endtask

    task automatic model_cycle(input bit t, input bit s, input bit kv,
                               input logic [1:0] kr, input logic [2:0] kc);
        int p;
        if (m_state != 1) begin
            if (s) begin
                model_reload();
                m_state = 1;
            end
        end else if (m_alive == 0) begin
            m_state = 2;
        end else begin
            if (t) begin
                p = 2 + $countones(m_alive);
                if (m_cnt == p - 1) begin
                    m_cnt = 0;
                    model_step();
                end else begin
                    m_cnt++;
                end
            end
            if (kv && kr < 3) m_alive[int'(kr)*8+int'(kc)] = 1'b0;
        end
    endtask

    task automatic drive(input bit t, input bit s, input bit kv,
                         input logic [1:0] kr, input logic [2:0] kc);
        exp_t e;
        bus.frame_tick = t;
        bus.start      = s;
        bus.kill_valid = kv;
        bus.kill_row   = kr;
        bus.kill_col   = kc;
        model_cycle(t, s, kv, kr, kc);
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.kill_valid = 1'b0;
        if (bus.step_pulse) begin
            pulses++;
            chk("step_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("step_base_x", bus.base_x, e.bx);
                chk("step_base_y", bus.base_y, e.by);
                chk("step_dir", bus.dir, e.dir);
                chk("step_landed", bus.landed, e.landed);
            end
        end
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) begin
            drive(1, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic tick_until_step(output int n);
        int p0;
        p0 = pushes;
        n  = 0;
        while (pushes == p0 && n < 100) begin
            drive(1, 0, 0, 0, 0);
            n++;
            if (pushes == p0) drive(0, 0, 0, 0, 0);
        end
        chk("step_seen_by_dut", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.kill_valid = 1'b0;
        bus.kill_row   = '0;
        bus.kill_col   = '0;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        model_reload();
        m_state = 0;
        sb.delete();
    endtask

    task automatic chk_reload(input string tag);
        chk({tag, "_base_x"}, bus.base_x, 40);
        chk({tag, "_base_y"}, bus.base_y, 40);
        chk({tag, "_dir"}, bus.dir, 1);
        chk({tag, "_alive"}, bus.alive, 24'hFFFFFF);
    endtask

    initial begin
        int n, p0, k;
        do_reset();
        chk_reload("reset");
        chk("reset_step", bus.step_pulse, 0);
        chk("reset_clear", bus.wave_clear, 0);
        chk("reset_landed", bus.landed, 0);

        p0 = pulses;
        idle_ticks(100);
        chk("idle_no_step", pulses - p0, 0);
        chk("idle_base_x", bus.base_x, 40);

        drive(0, 1, 0, 0, 0);
        p0 = pulses;
        idle_ticks(25);
        chk("no_step_before_26", pulses - p0, 0);
        drive(1, 0, 0, 0, 0);
        chk("step_after_26", bus.step_pulse, 1);
        chk("first_base_x", bus.base_x, 48);
        drive(0, 0, 0, 0, 0);
        chk("pulse_one_cycle", bus.step_pulse, 0);
        chk("one_step", pulses - p0, 1);

        repeat (10) tick_until_step(n);
        chk("edge_base_x", bus.base_x, 128);
        tick_until_step(n);
        chk("desc_base_x", bus.base_x, 128);
        chk("desc_base_y", bus.base_y, 56);
        chk("desc_dir", bus.dir, 0);

        drive(0, 0, 1, 0, 7);
        chk("kill_r0c7", bus.alive[7], 0);
        drive(0, 0, 1, 1, 7);
        chk("kill_r1c7", bus.alive[15], 0);
        drive(0, 0, 1, 0, 7);
        drive(0, 0, 1, 3, 0);
        chk("ignore_bad_kill", bus.alive, 24'hFF7F7F);

        p0 = pulses;
        idle_ticks(23);
        chk("no_step_before_24", pulses - p0, 0);
        drive(1, 0, 1, 2, 7);
        chk("coinc_step", bus.step_pulse, 1);
        chk("coinc_base_x", bus.base_x, 120);
        chk("coinc_alive", bus.alive, 24'h7F7F7F);
        tick_until_step(n);
        chk("period_23", n, 23);

        k = 0;
        while (m_state != 3 && k < 60) begin
            tick_until_step(n);
            k++;
        end
        chk("land_base_x", bus.base_x, 192);
        chk("land_base_y", bus.base_y, 88);
        chk("land_dir", bus.dir, 0);
        chk("landed", bus.landed, 1);
        p0 = pulses;
        idle_ticks(50);
        chk("landed_no_step", pulses - p0, 0);
        chk("landed_held", bus.landed, 1);

        drive(0, 1, 0, 0, 0);
        chk_reload("restart");
        chk("restart_landed", bus.landed, 0);

        tick_until_step(n);
        chk("restart_step_x", bus.base_x, 48);
        drive(0, 1, 0, 0, 0);
        chk("start_ignored", bus.base_x, 48);
        idle_ticks(5);
        do_reset();
        chk_reload("midreset");
        chk("midreset_step", bus.step_pulse, 0);
        chk("midreset_clear", bus.wave_clear, 0);
        chk("midreset_landed", bus.landed, 0);
        p0 = pulses;
        idle_ticks(30);
        chk("idle_after_reset", pulses - p0, 0);
        drive(0, 1, 0, 0, 0);
        tick_until_step(n);
        chk("cnt_cleared", n, 26);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                drive(0, 0, 1, 2'(r), 3'(c));
        chk("all_dead", bus.alive, 0);
        chk("clear_not_yet", bus.wave_clear, 0);
        drive(0, 0, 0, 0, 0);
        chk("wave_clear", bus.wave_clear, 1);
        p0 = pulses;
        idle_ticks(50);
        chk("clear_no_step", pulses - p0, 0);
        drive(0, 1, 0, 0, 0);
        chk_reload("clear_restart");
        chk("clear_restart_wc", bus.wave_clear, 0);

        chk("sb_empty", sb.size(), 0);
        chk("pulse_count", pulses, pushes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
